// File: rtl/pfb_input_commutator.sv
`default_nettype none
// ============================================================================
// Module      : pfb_input_commutator
// Description : Input commutator for a 2x-oversampled polyphase filter bank.
//               Wideband I/Q samples are written into a circular buffer of
//               depth 2M. After the M-th accepted input, and every M/2
//               inputs thereafter, a burst of M samples is read back,
//               newest-last (index M-1 down to 0), for the downstream
//               pfb_filter.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   NUM_CHANNELS        number of channels M (power of two, >= 4)
//   CHANNEL_INDEX_WIDTH width of Output_index
//   DATA_WIDTH          signed I/Q sample width
// Ports
//   Clk                  in   rising-edge clock
//   Rst                  in   synchronous reset, active low
//   Input_valid          in   input sample strobe (no backpressure)
//   Input_i / Input_q    in   signed wideband sample
//   Output_valid         out  burst sample strobe
//   Output_index         out  channel index k of the burst sample
//   Output_last          out  high on the k = 0 sample of a burst
//   Output_i / Output_q  out  buffered sample s[n-k]
//   Error_input_overflow out  one-cycle pulse when a frame is dropped
// ============================================================================
module pfb_input_commutator #(
    parameter int NUM_CHANNELS        = 32,
    parameter int CHANNEL_INDEX_WIDTH = $clog2(NUM_CHANNELS),
    parameter int DATA_WIDTH          = 12
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           Input_valid,
    input  logic signed [DATA_WIDTH-1:0]   Input_i,
    input  logic signed [DATA_WIDTH-1:0]   Input_q,
    output logic                           Output_valid,
    output logic [CHANNEL_INDEX_WIDTH-1:0] Output_index,
    output logic                           Output_last,
    output logic signed [DATA_WIDTH-1:0]   Output_i,
    output logic signed [DATA_WIDTH-1:0]   Output_q,
    output logic                           Error_input_overflow
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_depth  = 2 * NUM_CHANNELS;
    localparam int c_addr_w = CHANNEL_INDEX_WIDTH + 1;
    localparam int c_cnt_w  = CHANNEL_INDEX_WIDTH + 1;

    // Input count (minus one) at which a trigger fires: the first frame needs
    // a full M inputs, every later frame advances by M/2 (2x oversampling).
    localparam logic [c_cnt_w-1:0] c_first_trig = c_cnt_w'(NUM_CHANNELS - 1);
    localparam logic [c_cnt_w-1:0] c_next_trig  = c_cnt_w'(NUM_CHANNELS / 2 - 1);
    localparam logic [CHANNEL_INDEX_WIDTH-1:0] c_k_top =
        CHANNEL_INDEX_WIDTH'(NUM_CHANNELS - 1);

    // ------------------------------------------------------------------------
    // Input side: write pointer and frame counter
    // ------------------------------------------------------------------------
    logic                  w_accept;
    logic                  w_trigger;
    logic [c_addr_w-1:0]   wr_ptr_q;
    logic [c_cnt_w-1:0]    in_cnt_q;
    logic                  first_frame_q;

    // Inputs strobed while reset is asserted are ignored entirely, including
    // the buffer write.
    assign w_accept  = Input_valid & Rst;
    assign w_trigger = w_accept &&
                       (in_cnt_q == (first_frame_q ? c_first_trig : c_next_trig));

    // The buffer depth is a power of two, so the pointer wraps 2M-1 -> 0 on
    // its natural overflow.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            wr_ptr_q      <= '0;
            in_cnt_q      <= '0;
            first_frame_q <= 1'b1;
        end else if (w_accept) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
            // A dropped frame still restarts the count, so the frame grid
            // is never disturbed by an overflow.
            if (w_trigger) begin
                in_cnt_q      <= '0;
                first_frame_q <= 1'b0;
            end else begin
                in_cnt_q <= in_cnt_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Burst state machine
    // ------------------------------------------------------------------------
    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t                         state_q, state_d;
    logic [CHANNEL_INDEX_WIDTH-1:0] k_q, k_d;
    logic [c_addr_w-1:0]            base_q, base_d;
    logic                           w_rd_en;
    logic                           w_overflow;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            base_q  <= base_d;
        end
    end

    // base_q holds the buffer slot of the trigger sample s[n]; the burst
    // reads slot base - k for k = M-1 down to 0, one per cycle.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        base_d     = base_q;
        w_rd_en    = 1'b0;
        w_overflow = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_trigger) begin
                    state_d = S_BURST;
                    k_d     = c_k_top;
                    base_d  = wr_ptr_q;
                end
            end
            S_BURST: begin
                w_rd_en = 1'b1;
                if (k_q == '0) begin
                    // The final read frees the reader on this very edge, so a
                    // coincident trigger chains straight into the next burst.
                    if (w_trigger) begin
                        state_d = S_BURST;
                        k_d     = c_k_top;
                        base_d  = wr_ptr_q;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    k_d = k_q - 1'b1;
                    // Reader still busy: this frame is lost, burst continues.
                    if (w_trigger) begin
                        w_overflow = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Circular sample buffer (2M deep). Not reset: contents are only ever
    // read after M fresh writes. The registered read returns the old value
    // when the same slot is written on the same edge.
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] mem_i_q [c_depth];
    logic [DATA_WIDTH-1:0] mem_q_q [c_depth];
    logic [DATA_WIDTH-1:0] rd_i_q;
    logic [DATA_WIDTH-1:0] rd_q_q;
    logic [c_addr_w-1:0]   w_rd_addr;

    assign w_rd_addr = base_q - {1'b0, k_q};

    always_ff @(posedge Clk) begin
        if (w_accept) begin
            mem_i_q[wr_ptr_q] <= Input_i;
            mem_q_q[wr_ptr_q] <= Input_q;
        end
        if (w_rd_en) begin
            rd_i_q <= mem_i_q[w_rd_addr];
            rd_q_q <= mem_q_q[w_rd_addr];
        end
    end

    // ------------------------------------------------------------------------
    // Read pipeline and registered outputs. Read stage, then output stage:
    // first Output_valid lands two edges after the trigger edge.
    // ------------------------------------------------------------------------
    logic                           rd_valid_q;
    logic [CHANNEL_INDEX_WIDTH-1:0] rd_index_q;
    logic                           out_valid_q;
    logic [CHANNEL_INDEX_WIDTH-1:0] out_index_q;
    logic                           out_last_q;
    logic [DATA_WIDTH-1:0]          out_i_q;
    logic [DATA_WIDTH-1:0]          out_q_q;
    logic                           err_q;

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            rd_valid_q  <= 1'b0;
            rd_index_q  <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_last_q  <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            rd_valid_q  <= w_rd_en;
            rd_index_q  <= k_q;
            out_valid_q <= rd_valid_q;
            // Payload fields are forced to zero whenever the strobe is low.
            out_index_q <= rd_valid_q ? rd_index_q : '0;
            out_last_q  <= rd_valid_q && (rd_index_q == '0);
            out_i_q     <= rd_valid_q ? rd_i_q : '0;
            out_q_q     <= rd_valid_q ? rd_q_q : '0;
            err_q       <= w_overflow;
        end
    end

    assign Output_valid         = out_valid_q;
    assign Output_index         = out_index_q;
    assign Output_last          = out_last_q;
    assign Output_i             = out_i_q;
    assign Output_q             = out_q_q;
    assign Error_input_overflow = err_q;

endmodule
`default_nettype wire

// File: tb/tb_pfb_input_commutator.sv
`default_nettype none
// ============================================================================
// Module      : tb_pfb_input_commutator
// Description : Scoreboard bench for pfb_input_commutator (M = 32, 12-bit).
//               The driver issues directed and random input traffic and, on
//               every trigger, pushes the expected burst (or the expected
//               overflow pulse) into queues; a separate monitor pops and
//               compares on every clock.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pfb_input_commutator;

    localparam int M  = 32;
    localparam int DW = 12;
    localparam int IW = 5;

    logic                 Clk = 1'b0;
    logic                 Rst = 1'b0;
    logic                 Input_valid = 1'b0;
    logic signed [DW-1:0] Input_i = '0;
    logic signed [DW-1:0] Input_q = '0;
    logic                 Output_valid;
    logic [IW-1:0]        Output_index;
    logic                 Output_last;
    logic signed [DW-1:0] Output_i;
    logic signed [DW-1:0] Output_q;
    logic                 Error_input_overflow;

    always #5 Clk = ~Clk;

    pfb_input_commutator #(
        .NUM_CHANNELS        (M),
        .CHANNEL_INDEX_WIDTH (IW),
        .DATA_WIDTH          (DW)
    ) dut (
        .Clk                  (Clk),
        .Rst                  (Rst),
        .Input_valid          (Input_valid),
        .Input_i              (Input_i),
        .Input_q              (Input_q),
        .Output_valid         (Output_valid),
        .Output_index         (Output_index),
        .Output_last          (Output_last),
        .Output_i             (Output_i),
        .Output_q             (Output_q),
        .Error_input_overflow (Error_input_overflow)
    );

    typedef struct {
        int idx;
        bit last;
        int i;
        int q;
        int edge_no;
    } exp_t;

    exp_t exp_q[$];
    int   err_exp_q[$];
    int   obs_first[$];
    int   obs_first_edge[$];
    int   obs_valid = 0;
    int   obs_err   = 0;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    int hist_i [16384];
    int hist_q [16384];
    int nacc          = 0;
    int cnt_since_rst = 0;
    int last_trig     = -100000;

    task automatic chk(input bit ok, input string name, input string detail);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Reference model, run once per rising edge with the values the DUT saw.
    task automatic model_edge(input bit rst_v, input bit v, input int vi, input int vq);
        edge_n++;
        if (!rst_v) begin
            cnt_since_rst = 0;
            last_trig     = -100000;
            exp_q.delete();
            err_exp_q.delete();
        end else if (v) begin
            hist_i[nacc] = vi;
            hist_q[nacc] = vq;
            nacc++;
            cnt_since_rst++;
            if (cnt_since_rst == M ||
                (cnt_since_rst > M && ((cnt_since_rst - M) % (M / 2)) == 0)) begin
                if (edge_n - last_trig < M) begin
                    err_exp_q.push_back(edge_n);
                end else begin
                    last_trig = edge_n;
                    for (int k = M - 1; k >= 0; k--) begin
                        exp_t e;
                        e.idx     = k;
                        e.last    = (k == 0);
                        e.i       = hist_i[nacc - 1 - k];
                        e.q       = hist_q[nacc - 1 - k];
                        e.edge_no = edge_n + 2 + (M - 1 - k);
                        exp_q.push_back(e);
                    end
                end
            end
        end
    endtask

    // Inputs change only at the falling edge; one call = one rising edge.
    task automatic step(input bit r, input bit v, input int vi, input int vq);
        Rst         = r;
        Input_valid = v;
        Input_i     = DW'(vi);
        Input_q     = DW'(vq);
        @(posedge Clk);
        model_edge(r, v, vi, vq);
        @(negedge Clk);
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && (exp_q.size() != 0 || err_exp_q.size() != 0); n++)
            step(1'b1, 1'b0, 0, 0);
        repeat (4) step(1'b1, 1'b0, 0, 0);
        chk(exp_q.size() == 0 && err_exp_q.size() == 0, "drain",
            $sformatf("pending samples=%0d overflows=%0d, want 0/0",
                      exp_q.size(), err_exp_q.size()));
    endtask

    task automatic clear_obs();
        obs_first.delete();
        obs_first_edge.delete();
        obs_valid = 0;
        obs_err   = 0;
    endtask

    // ------------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------------
    initial begin
        forever begin
            @(negedge Clk);
            while (exp_q.size() != 0 && exp_q[0].edge_no < edge_n) begin
                chk(1'b0, "missing_sample",
                    $sformatf("idx %0d due at edge %0d not seen", exp_q[0].idx, exp_q[0].edge_no));
                void'(exp_q.pop_front());
            end
            while (err_exp_q.size() != 0 && err_exp_q[0] < edge_n) begin
                chk(1'b0, "missing_overflow",
                    $sformatf("pulse due at edge %0d not seen", err_exp_q[0]));
                void'(err_exp_q.pop_front());
            end
            if (Output_valid) begin
                obs_valid++;
                if (Output_index == IW'(M - 1)) begin
                    obs_first.push_back(int'(Output_i));
                    obs_first_edge.push_back(edge_n);
                end
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_valid",
                        $sformatf("edge %0d idx %0d i %0d, none expected", edge_n, Output_index, Output_i));
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk(int'(Output_index) == e.idx && Output_last == e.last &&
                        int'(Output_i) == e.i && int'(Output_q) == e.q && edge_n == e.edge_no,
                        "burst_sample",
                        $sformatf("got edge %0d idx %0d last %0b i %0d q %0d, want edge %0d idx %0d last %0b i %0d q %0d",
                                  edge_n, Output_index, Output_last, Output_i, Output_q,
                                  e.edge_no, e.idx, e.last, e.i, e.q));
                end
            end else begin
                chk(Output_index == '0 && !Output_last && Output_i == '0 && Output_q == '0,
                    "idle_zero",
                    $sformatf("idx %0d last %0b i %0d q %0d, want all 0",
                              Output_index, Output_last, Output_i, Output_q));
            end
            if (Error_input_overflow) begin
                obs_err++;
                if (err_exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_overflow", $sformatf("pulse at edge %0d, none expected", edge_n));
                end else begin
                    int x;
                    x = err_exp_q.pop_front();
                    chk(x == edge_n, "overflow_timing", $sformatf("pulse at edge %0d, want %0d", edge_n, x));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int trig_edge;
        int acc;

        // Reset with junk strobes that must be ignored.
        repeat (3) step(1'b0, 1'b1, 77, -77);
        chk(!Output_valid && Output_index == '0 && !Output_last && Output_i == '0 &&
            Output_q == '0 && !Error_input_overflow, "reset_outputs",
            $sformatf("valid %0b idx %0d i %0d err %0b, want 0",
                      Output_valid, Output_index, Output_i, Error_input_overflow));

        // Phase A: 48 inputs, one every two cycles -> bursts at 32 and 48.
        clear_obs();
        trig_edge = 0;
        for (int j = 1; j <= 48; j++) begin
            step(1'b1, 1'b1, j, -j);
            if (j == 32) trig_edge = edge_n;
            step(1'b1, 1'b0, 0, 0);
        end
        drain();
        chk(obs_first.size() == 2 && obs_first[0] == 1 && obs_first[1] == 17, "slow_bursts",
            $sformatf("bursts %0d first I %0d/%0d, want 2 with 1/17", obs_first.size(),
                      obs_first.size() > 0 ? obs_first[0] : -999,
                      obs_first.size() > 1 ? obs_first[1] : -999));
        chk(obs_first_edge.size() > 0 && obs_first_edge[0] == trig_edge + 2, "first_latency",
            $sformatf("first valid edge %0d, want %0d",
                      obs_first_edge.size() > 0 ? obs_first_edge[0] : -1, trig_edge + 2));
        chk(obs_valid == 64 && obs_err == 0, "slow_counts",
            $sformatf("valids %0d overflows %0d, want 64/0", obs_valid, obs_err));

        // Phase B: only 31 inputs after reset -> no output at all.
        repeat (2) step(1'b0, 1'b0, 0, 0);
        clear_obs();
        for (int j = 1; j <= 31; j++) begin
            step(1'b1, 1'b1, j, -j);
            step(1'b1, 1'b0, 0, 0);
        end
        repeat (60) step(1'b1, 1'b0, 0, 0);
        chk(obs_valid == 0, "no_burst_31", $sformatf("valids %0d, want 0", obs_valid));

        // Phase C: 64 back-to-back inputs -> burst, dropped frame, chained burst.
        repeat (2) step(1'b0, 1'b0, 0, 0);
        clear_obs();
        for (int j = 1; j <= 64; j++) step(1'b1, 1'b1, j, -j);
        drain();
        chk(obs_first.size() == 2 && obs_first[0] == 1 && obs_first[1] == 33, "fast_bursts",
            $sformatf("bursts %0d first I %0d/%0d, want 2 with 1/33", obs_first.size(),
                      obs_first.size() > 0 ? obs_first[0] : -999,
                      obs_first.size() > 1 ? obs_first[1] : -999));
        chk(obs_err == 1 && obs_valid == 64, "fast_counts",
            $sformatf("overflows %0d valids %0d, want 1/64", obs_err, obs_valid));
        chk(obs_first_edge.size() == 2 && obs_first_edge[1] - obs_first_edge[0] == M, "no_gap_chain",
            $sformatf("burst spacing %0d, want %0d",
                      obs_first_edge.size() == 2 ? obs_first_edge[1] - obs_first_edge[0] : -1, M));

        // Phase D: reset in the middle of a burst (index 15).
        repeat (2) step(1'b0, 1'b0, 0, 0);
        clear_obs();
        for (int j = 1; j <= 32; j++) step(1'b1, 1'b1, 100 + j, -(100 + j));
        repeat (18) step(1'b1, 1'b0, 0, 0);
        chk(Output_valid && Output_index == 5'd15, "abort_point",
            $sformatf("valid %0b idx %0d, want 1/15", Output_valid, Output_index));
        step(1'b0, 1'b0, 0, 0);
        chk(!Output_valid && Output_index == '0 && !Output_last && Output_i == '0 && Output_q == '0,
            "abort_outputs", $sformatf("valid %0b idx %0d i %0d, want 0", Output_valid, Output_index, Output_i));
        step(1'b0, 1'b1, 5, 5);
        clear_obs();
        for (int j = 1; j <= 31; j++) step(1'b1, 1'b1, 200 + j, -(200 + j));
        repeat (40) step(1'b1, 1'b0, 0, 0);
        chk(obs_valid == 0, "abort_no_early_burst", $sformatf("valids %0d, want 0", obs_valid));
        step(1'b1, 1'b1, 232, -232);
        drain();
        chk(obs_first.size() == 1 && obs_first[0] == 201, "abort_rearm",
            $sformatf("bursts %0d first I %0d, want 1 with 201", obs_first.size(),
                      obs_first.size() > 0 ? obs_first[0] : -999));

        // Phase E: random traffic, 10000 accepted inputs.
        repeat (2) step(1'b0, 1'b0, 0, 0);
        clear_obs();
        acc = 0;
        while (acc < 10000) begin
            if ($urandom_range(0, 3) != 0) begin
                step(1'b1, 1'b1, int'($urandom_range(0, 4095)) - 2048,
                     int'($urandom_range(0, 4095)) - 2048);
                acc++;
            end else begin
                step(1'b1, 1'b0, 0, 0);
            end
        end
        drain();
        chk(obs_valid > 0 && obs_valid % M == 0, "random_bursts",
            $sformatf("valids %0d, want a nonzero multiple of %0d", obs_valid, M));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pfb_input_commutator.md
PFB_INPUT_COMMUTATOR -- requirements
Module: pfb_input_commutator

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 32: number of channels M; power of two, at least 4.
REQ-002 SHALL have parameter CHANNEL_INDEX_WIDTH, default $clog2(NUM_CHANNELS): width of Output_index.
REQ-003 SHALL have parameter DATA_WIDTH, default 12: signed I/Q sample width, input and output.
REQ-004 SHALL have port Clk, in, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port Rst, in, 1: reset; synchronous, active-low (0 = reset).
REQ-006 SHALL have port Input_valid, in, 1: sample strobe; no backpressure, every strobed sample is accepted.
REQ-007 SHALL have ports Input_i and Input_q, in, DATA_WIDTH each: signed wideband I/Q sample.
REQ-008 SHALL have port Output_valid, out, 1: output sample strobe for the downstream pfb_filter.
REQ-009 SHALL have port Output_index, out, CHANNEL_INDEX_WIDTH: channel index of the output sample.
REQ-010 SHALL have port Output_last, out, 1: high on the final sample of a burst (index 0).
REQ-011 SHALL have ports Output_i and Output_q, out, DATA_WIDTH each: buffered sample, bit-exact copy of the input.
REQ-012 SHALL have port Error_input_overflow, out, 1: one-cycle pulse when a frame is dropped.

Function
REQ-013 SHALL implement 2x-oversampled commutation: one burst of M output samples per M/2 accepted inputs.
REQ-014 SHALL store inputs in a circular buffer of depth 2M; the write pointer advances by 1 per accepted input, wrapping 2M-1 -> 0.
REQ-015 SHALL count accepted inputs since reset; the first trigger is the M-th input; later triggers are every M/2 inputs after that.
REQ-016 SHALL treat trigger input s[n] as the newest sample of the frame: the burst emits, for k = M-1 down to 0, Output_index = k, Output_i/q = s[n-k].
REQ-017 SHALL emit burst samples on M consecutive cycles with no gaps; Output_last is high only at k = 0.
REQ-018 SHALL assert the first Output_valid of a burst 2 cycles after the edge on which the trigger input is sampled.
REQ-019 SHALL register all outputs; Output_i/q/index/last SHALL be 0 when Output_valid = 0.
REQ-020 SHALL use the state machine IDLE -> BURST (on trigger) -> IDLE (after the k = 0 read).
REQ-021 SHALL start the next burst in the cycle immediately after k = 0 if a trigger occurs on that same edge, with no idle cycle.
REQ-022 SHALL, on a trigger while in BURST, drop that frame, pulse Error_input_overflow for one cycle, and leave the current burst unaffected.
REQ-023 SHALL still write the input into the buffer and advance the frame counter for a dropped frame.
REQ-024 SHALL return the previously stored value when a read and a write address the same buffer slot on the same edge (read-before-write).
REQ-025 SHALL, by depth and read order, guarantee that no sample of an active burst is overwritten before it is read when inputs arrive every cycle.

Reset
REQ-026 SHALL, while Rst = 0, drive Output_valid, Output_last, Output_index, Output_i, Output_q and Error_input_overflow to 0.
REQ-027 SHALL, while Rst = 0, clear the write pointer and input counter and force IDLE.
REQ-028 SHALL abort any burst in progress on reset with no further outputs; buffer contents need not be cleared.
REQ-029 SHALL require M fresh inputs after reset release before the first burst.
REQ-030 SHALL ignore Input_valid during reset.

Verification (M = 32, DATA_WIDTH = 12)
REQ-031 Reset; 32 inputs, one every 2 cycles, I = 1..32, Q = -1..-32 -> exactly one burst:
- index 31..0;
- I = 1..32, Q = -1..-32;
- last only at index 0;
- first Output_valid 2 cycles after input 32.
REQ-032 Continue with inputs 33..48 -> second burst I = 17..48, index 31..0. Only 31 inputs after reset -> no Output_valid.
REQ-033 64 inputs on consecutive cycles after reset:
- burst at input 32;
- trigger at input 48 occurs mid-burst -> one Error_input_overflow pulse, that frame dropped;
- trigger at input 64 starts a burst with I = 33..64;
- no gaps inside any burst.
REQ-034 Trigger on the same edge as the k = 0 read -> next burst starts the following cycle, no idle cycle, no error.
REQ-035 Rst = 0 at burst index 15 -> all outputs 0 next cycle; after release, 32 new inputs are needed before the next burst.
REQ-036 Continuous random traffic, 10000 inputs -> every Output_i/q matches the software model, including read-before-write slots.
